inst_encoder: RTL
=================

Name: inst_encoder

Overview:
Reverse of the instruction field decoder. Accepts per-instruction field bundles (format, opcode, rd, funct3, rs1, rs2, funct7, immediate) over a valid/ready stream. Packs each bundle into a 32-bit RV32 word and buffers it in a small FIFO. Emits the words with an incrementing load address, for the program loader and the bench instruction generator that fill instruction memory.

Parameters:
FIFO_DEPTH, 4, output buffer entries; power of two, at least 2
BASE_ADDR, 32'h0000_0000, first emitted address after start
ADDR_STEP, 4, address increment per emitted word

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a session from IDLE
in_valid  in  1  field bundle valid
in_ready  out  1  encoder can accept a bundle
in_last  in  1  bundle is the final one of the session
in_fmt  in  3  rv32_pkg::fmt_t: R, I, S, B, U, J
in_opcode  in  7  rv32_pkg::opcode_t
in_rd  in  5  destination register
in_funct3  in  3  rv32_pkg::funct3_t
in_rs1  in  5  source register 1
in_rs2  in  5  source register 2
in_funct7  in  7  funct7
in_imm  in  32  signed byte immediate; for U format, already left-aligned (value<<12)
out_valid  out  1  encoded word available
out_ready  in  1  sink accepts the word
out_inst  out  32  encoded instruction
out_addr  out  32  load address of out_inst
done  out  1  one-cycle pulse after the last word is accepted
err  out  1  sticky immediate-range error (optional feature only)

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE; FIFO empty; address counter = BASE_ADDR.
  - in_ready=0, out_valid=0, out_inst=0, out_addr=BASE_ADDR, done=0, err=0.
- FSM states:
  - IDLE: in_ready=0. start -> RUN; address counter reloads BASE_ADDR; err clears.
  - RUN: in_ready = !fifo_full. An accepted bundle with in_last=1 -> DRAIN.
  - DRAIN: in_ready=0. FIFO empty -> DONE.
  - DONE: done=1 for exactly one cycle -> IDLE.
  - start outside IDLE is ignored.
- Handshakes:
  - Input transfer on in_valid && in_ready.
  - Output transfer on out_valid && out_ready.
  - out_valid = !fifo_empty.
  - out_inst and out_addr hold stable while out_valid && !out_ready.
- Encoding is combinational at FIFO write. Bit layouts, MSB to LSB:
  - R: funct7|rs2|rs1|funct3|rd|opcode
  - I: imm[11:0]|rs1|funct3|rd|opcode
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode
  - U: imm[31:12]|rd|opcode
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode
  - Unused fields are ignored. An undefined fmt encodes as 32'h0000_0013 (nop).
- Latency: a bundle accepted in cycle N gives out_valid in cycle N+1 (registered FIFO). Full-rate throughput is 1 word/cycle when out_ready=1.
- Address: out_addr is stored per entry. The counter increments by ADDR_STEP on each FIFO write and wraps modulo 2^32.
- FIFO boundaries:
  - Full: in_ready=0.
  - Simultaneous push and pop when full: push is not accepted, because in_ready is already 0 (no fall-through).
  - Push and pop in the same cycle when non-empty: occupancy unchanged.
  - Push to an empty FIFO is not visible until the next cycle.
- Reset mid-session: FIFO flushes, state returns to IDLE, and no done pulse is issued.

Optional Feature:
INST_ENCODER_RANGE_CHECK_EN
- Defined:
  - The immediate must be representable in its format:
    - I and S: in [-2048, 2047].
    - B: in [-4096, 4094] and even.
    - J: in [-2^20, 2^20-2] and even.
    - U: imm[11:0] must be 0.
  - A violation sets err (sticky until the next start). The word is still encoded, truncated.
- Undefined: err is tied to 0; immediates are silently truncated to the field bits.

Decomposition:
- rv32_pkg gains:
  - fmt_t enum: FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J.
  - Constant NOP_INST = 32'h0000_0013.
  - A function encode_inst(fmt, fields) so the decoder bench can reuse it.
- opcode_t and funct3_t are reused from rv32_pkg.
- One sub-module: enc_fifo, a synchronous FIFO parameterised on width and depth, storing {addr, inst}. The FSM and address counter stay in inst_encoder.

Test Plan:
1. Encodings, with out_ready=1:
   - start; I addi rd=1 rs1=0 f3=0 imm=5 op=0x13 -> out_inst 0x00500093, out_addr 0x0.
   - R add rd=3 rs1=1 rs2=2 -> 0x002081B3, addr 0x4.
2. Encodings:
   - S sw rs1=1 rs2=2 f3=2 imm=8 -> 0x0020A423.
   - B beq rs1=1 rs2=2 imm=-4 -> 0xFE208EE3.
   - U lui rd=5 imm=0x12345000 -> 0x123452B7.
   - J jal rd=1 imm=8 -> 0x008000EF.
3. Backpressure: out_ready=0, push 5 bundles with FIFO_DEPTH=4 -> in_ready drops after the 4th accept. Release out_ready -> 4 words in order at addresses 0, 4, 8, 12, then the 5th at 16; no loss or duplication.
4. Session end: last bundle with in_last=1 -> in_ready=0 next cycle; done pulses exactly once, one cycle after the final out transfer; state returns to IDLE; a new start reloads BASE_ADDR.
5. Reset mid-session: assert rst_n=0 with 3 words queued -> out_valid=0 immediately; no done; next session starts at BASE_ADDR.
6. With INST_ENCODER_RANGE_CHECK_EN defined:
   - I imm=4096 -> err=1 and stays 1; a subsequent valid word does not clear it.
   - Without the macro, the same stimulus -> err=0 and the word is truncated to imm[11:0]=0.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32 encoding definitions: instruction formats, opcode/funct3
// constants, the field bundle, encoder FSM states and the pure encode helper.
package rv32_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_t;

  typedef logic [6:0] opcode_t;
  localparam opcode_t OPC_LUI    = 7'h37;
  localparam opcode_t OPC_AUIPC  = 7'h17;
  localparam opcode_t OPC_JAL    = 7'h6F;
  localparam opcode_t OPC_JALR   = 7'h67;
  localparam opcode_t OPC_BRANCH = 7'h63;
  localparam opcode_t OPC_LOAD   = 7'h03;
  localparam opcode_t OPC_STORE  = 7'h23;
  localparam opcode_t OPC_IMM    = 7'h13;
  localparam opcode_t OPC_REG    = 7'h33;

  // funct3 values overlap between instruction classes, so this is a plain
  // vector type with named constants rather than an enum.
  typedef logic [2:0] funct3_t;
  localparam funct3_t F3_ADD = 3'd0;
  localparam funct3_t F3_BEQ = 3'd0;
  localparam funct3_t F3_LW  = 3'd2;
  localparam funct3_t F3_SW  = 3'd2;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    opcode_t     opcode;
    logic [4:0]  rd;
    funct3_t     funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } inst_fields_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } enc_state_t;

  // Pack a field bundle into a 32-bit word; unknown formats become a nop.
  function automatic logic [31:0] encode_inst(input logic [2:0] fmt, input inst_fields_t f);
    logic [31:0] w;
    w = NOP_INST;
    case (fmt)
      FMT_R: w = {f.funct7, f.rs2, f.rs1, f.funct3, f.rd, f.opcode};
      FMT_I: w = {f.imm[11:0], f.rs1, f.funct3, f.rd, f.opcode};
      FMT_S: w = {f.imm[11:5], f.rs2, f.rs1, f.funct3, f.imm[4:0], f.opcode};
      FMT_B: w = {f.imm[12], f.imm[10:5], f.rs2, f.rs1, f.funct3, f.imm[4:1], f.imm[11], f.opcode};
      FMT_U: w = {f.imm[31:12], f.rd, f.opcode};
      FMT_J: w = {f.imm[20], f.imm[10:1], f.imm[11], f.imm[19:12], f.rd, f.opcode};
      default: w = NOP_INST;
    endcase
    return w;
  endfunction

  // True when the immediate fits its format without truncation: the bits
  // above the field's sign bit must all copy it, and B/J offsets must be even.
  function automatic logic imm_in_range(input logic [2:0] fmt, input logic [31:0] imm);
    logic ok;
    ok = 1'b1;
    case (fmt)
      FMT_I, FMT_S: ok = (imm[31:11] == {21{imm[11]}});
      FMT_B:        ok = (imm[31:12] == {20{imm[12]}}) && !imm[0];
      FMT_J:        ok = (imm[31:20] == {12{imm[20]}}) && !imm[0];
      FMT_U:        ok = (imm[11:0] == 12'd0);
      default:      ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/enc_fifo.sv
// Synchronous FIFO for encoded {addr, inst} entries. Pointers and occupancy
// reset asynchronously; storage is not reset. The head entry is presented
// combinationally, so a write becomes visible the cycle after it lands.
module enc_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  import rv32_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_wr, do_rd;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;

  // Next pointers and occupancy; depth is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/inst_encoder.sv
// Instruction encoder: packs field bundles into RV32 words, buffers them with
// their load addresses and streams them out, framed by start / done.
// Optional immediate range checking is enabled by INST_ENCODER_RANGE_CHECK_EN.
module inst_encoder
  import rv32_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter logic [31:0] ADDR_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_last,
  input  logic [2:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [2:0]  in_funct3,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_addr,
  output logic        done,
  output logic        err
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  enc_state_t   state_q, state_d;
  logic [31:0]  addr_q, addr_d;
  inst_fields_t fields;
  logic [31:0]  inst_word;
  logic [63:0]  fifo_rd_data;
  logic         fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic         in_accept, out_accept, start_ok;

  assign fields = '{opcode: in_opcode, rd: in_rd, funct3: in_funct3, rs1: in_rs1,
                    rs2: in_rs2, funct7: in_funct7, imm: in_imm};
  assign inst_word  = encode_inst(in_fmt, fields);
  assign in_accept  = in_valid && in_ready;
  assign out_accept = out_valid && out_ready;
  assign start_ok   = start && (state_q == ST_IDLE);

  enc_fifo #(.WIDTH(64), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (in_accept),
    .wr_data ({addr_q, inst_word}),
    .rd_en   (out_accept),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // While empty the head entry is stale storage, so show zero and the next address.
  assign out_valid = !fifo_empty;
  assign out_inst  = fifo_empty ? 32'd0 : fifo_rd_data[31:0];
  assign out_addr  = fifo_empty ? addr_q : fifo_rd_data[63:32];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state; DRAIN leaves as the final word is taken so done follows that transfer directly.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_RUN;
      ST_RUN:   if (in_accept && in_last) state_d = ST_DRAIN;
      ST_DRAIN: if (fifo_empty || (out_accept && fifo_count == CNT_W'(1))) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    in_ready = 1'b0;
    done     = 1'b0;
    case (state_q)
      ST_RUN:  in_ready = !fifo_full;
      ST_DONE: done     = 1'b1;
      default: begin
        in_ready = 1'b0;
        done     = 1'b0;
      end
    endcase
  end

  // Load address counter: reloads on a session start, advances per accepted bundle.
  always_comb begin
    addr_d = addr_q;
    if (start_ok)       addr_d = BASE_ADDR;
    else if (in_accept) addr_d = addr_q + ADDR_STEP;
  end

  // Address counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) addr_q <= BASE_ADDR;
    else        addr_q <= addr_d;
  end

`ifdef INST_ENCODER_RANGE_CHECK_EN
  logic err_q, err_d;

  // Sticky range error: cleared by a session start, set by any out-of-range accepted bundle.
  always_comb begin
    err_d = err_q;
    if (start_ok) err_d = 1'b0;
    else if (in_accept && !imm_in_range(in_fmt, in_imm)) err_d = 1'b1;
  end

  // Error flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
